// File: rtl/bcd_conv_sched_if.sv
// Request/result bus for the two-requester binary-to-BCD converter.
// slave  : converter side (takes requests, drives readies and results)
// master : requester/consumer side
interface bcd_conv_sched_if;
  logic       req0_valid;
  logic [7:0] req0_bin;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_bin;
  logic       req1_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_id;
  logic [3:0] out_hundreds;
  logic [3:0] out_tens;
  logic [3:0] out_ones;
  logic       busy;

  modport slave (
    input  req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
    output req0_ready, req1_ready, out_valid, out_id,
           out_hundreds, out_tens, out_ones, busy
  );

  modport master (
    output req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
    input  req0_ready, req1_ready, out_valid, out_id,
           out_hundreds, out_tens, out_ones, busy
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduled 8-bit binary to 3-digit BCD converter (double dabble).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave modport of bcd_conv_sched_if
//                req0/req1 valid/bin/ready request channels (readies are combinational),
//                out_valid/out_ready result handshake with out_id and BCD digits,
//                busy high whenever the FSM is not idle.
// One conversion takes a transfer cycle, 8 shift cycles and at least one result cycle.
module bcd_conv_sched #(
  parameter int unsigned W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_conv_sched_if.slave    bus
);

  localparam int unsigned DIG_W = 4;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic               out_valid_q;
  logic               busy_q;

  logic               last_q;
  logic               id_q;
  logic [W-1:0]       bin_q;
  logic [DIG_W-1:0]   hun_q;
  logic [DIG_W-1:0]   ten_q;
  logic [DIG_W-1:0]   one_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               out_id_q;
  logic [DIG_W-1:0]   out_hun_q;
  logic [DIG_W-1:0]   out_ten_q;
  logic [DIG_W-1:0]   out_one_q;

  logic               grant_id_c;
  logic               ready0_c;
  logic               ready1_c;
  logic               xfer_c;
  logic               last_step_c;
  logic [DIG_W-1:0]   hun_n;
  logic [DIG_W-1:0]   ten_n;
  logic [DIG_W-1:0]   one_n;

  // Adjust-then-shift of one digit: low 3 bits of the adjusted digit move up,
  // cin enters bit 0. The bit leaving a digit is simply (digit >= 5).
  function automatic logic [DIG_W-1:0] dabble(input logic [DIG_W-1:0] d, input logic cin);
    logic [2:0] lo;
    lo = (d >= 4'd5) ? (d[2:0] + 3'd3) : d[2:0];
    return {lo, cin};
  endfunction

  // Arbitration: a tie goes to the requester not granted last.
  always_comb begin
    grant_id_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id_c = ~last_q;
    end else if (bus.req1_valid) begin
      grant_id_c = 1'b1;
    end
    ready0_c = rst_n && (state_q == IDLE) && bus.req0_valid && !grant_id_c;
    ready1_c = rst_n && (state_q == IDLE) && bus.req1_valid &&  grant_id_c;
    xfer_c   = ready0_c || ready1_c;
  end

  assign last_step_c = (state_q == CONVERT) && (cnt_q == CNT_W'(W - 1));

  // One double-dabble step across {hundreds, tens, ones, bin}.
  always_comb begin
    hun_n = dabble(hun_q, ten_q >= 4'd5);
    ten_n = dabble(ten_q, one_q >= 4'd5);
    one_n = dabble(one_q, bin_q[W-1]);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer_c)        state_d = CONVERT;
      CONVERT: if (last_step_c)   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // State register with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Capture, shift and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      bin_q     <= '0;
      hun_q     <= '0;
      ten_q     <= '0;
      one_q     <= '0;
      cnt_q     <= '0;
      out_id_q  <= 1'b0;
      out_hun_q <= '0;
      out_ten_q <= '0;
      out_one_q <= '0;
    end else if (xfer_c) begin
      bin_q  <= ready1_c ? W'(bus.req1_bin) : W'(bus.req0_bin);
      id_q   <= ready1_c;
      last_q <= ready1_c;
      hun_q  <= '0;
      ten_q  <= '0;
      one_q  <= '0;
      cnt_q  <= '0;
    end else if (state_q == CONVERT) begin
      hun_q <= hun_n;
      ten_q <= ten_n;
      one_q <= one_n;
      bin_q <= {bin_q[W-2:0], 1'b0};
      cnt_q <= cnt_q + CNT_W'(1);
      // Result registers change only when a conversion completes.
      if (last_step_c) begin
        out_id_q  <= id_q;
        out_hun_q <= hun_n;
        out_ten_q <= ten_n;
        out_one_q <= one_n;
      end
    end
  end

  assign bus.req0_ready   = ready0_c;
  assign bus.req1_ready   = ready1_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = busy_q;
  assign bus.out_id       = out_id_q;
  assign bus.out_hundreds = out_hun_q;
  assign bus.out_tens     = out_ten_q;
  assign bus.out_ones     = out_one_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: stimulus pushes expected {id, digits},
// a negedge monitor pops and compares whenever a result is handed off.
module tb_bcd_conv_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_conv_sched_if bus();

  bcd_conv_sched #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [12:0] sb[$];
  logic [12:0] exp_v;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Result monitor and single-grant check.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_ready || bus.req1_ready)
        check("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_out: got 0x%0h expected none at %0t",
                   {bus.out_id, bus.out_hundreds, bus.out_tens, bus.out_ones}, $time);
        end else begin
          exp_v = sb.pop_front();
          check("result", 32'({bus.out_id, bus.out_hundreds, bus.out_tens, bus.out_ones}),
                32'(exp_v));
        end
      end
    end
  end

  // Present a value, wait for its grant, record the expected result, drop valid.
  task automatic grant(input bit id, input logic [7:0] val, input logic [11:0] exp_d);
    int n;
    logic r;
    @(posedge clk); #1;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_bin = val; end
    else    begin bus.req0_valid = 1'b1; bus.req0_bin = val; end
    n = 0;
    do begin
      @(negedge clk); n++;
      r = id ? bus.req1_ready : bus.req0_ready;
    end while (!r && n < 40);
    check("grant_wait", 32'(r), 1);
    sb.push_back({id, exp_d});
    @(posedge clk); #1;
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  // Count edges from the transfer edge until out_valid rises.
  task automatic wait_out(input int start);
    int lat;
    lat = start;
    do begin @(posedge clk); #1; lat++; end while (!bus.out_valid && lat < 40);
    check("latency", 32'(lat), 8);
  endtask

  task automatic send(input bit id, input logic [7:0] val, input logic [11:0] exp_d);
    grant(id, val, exp_d);
    wait_out(0);
    @(posedge clk); #1;
    check("idle_after", 32'({bus.busy, bus.out_valid}), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("drain", 32'(sb.size()), 0);
  endtask

  logic [7:0]  cv [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199};
  logic [11:0] ce [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h199};
  bit hold_ok;
  int got;

  initial begin
    bus.req0_valid = 1'b0; bus.req0_bin = '0;
    bus.req1_valid = 1'b0; bus.req1_bin = '0;
    bus.out_ready  = 1'b1;

    // Reset state, with both requesters asking.
    repeat (2) @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    check("rst_state", 32'({bus.out_valid, bus.busy, bus.out_id, bus.out_hundreds,
                            bus.out_tens, bus.out_ones, bus.req0_ready, bus.req1_ready}), 0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round robin with both pending, first tie after reset to requester 0.
    bus.req0_bin = 8'd37; bus.req1_bin = 8'd200;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!(bus.req0_ready || bus.req1_ready) && n < 40);
      got = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : 2);
      check("rr_grant", 32'(got), 32'(g % 2));
      sb.push_back((g % 2) ? {1'b1, 12'h200} : {1'b0, 12'h037});
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain();

    // Max value.
    send(1'b0, 8'd255, 12'h255);

    // Corner values.
    for (int i = 0; i < 6; i++) send(1'b0, cv[i], ce[i]);

    // Input changes during conversion are ignored.
    grant(1'b0, 8'd50, 12'h050);
    bus.req0_bin = 8'd77; bus.req0_valid = 1'b1;
    repeat (3) @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_out(3);
    @(posedge clk); #1;
    check("idle_after_chg", 32'({bus.busy, bus.out_valid}), 0);

    // Backpressure with another request pending.
    bus.out_ready = 1'b0;
    grant(1'b0, 8'd123, 12'h123);
    bus.req1_bin = 8'd5; bus.req1_valid = 1'b1;
    wait_out(0);
    hold_ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!(bus.out_valid && bus.busy && !bus.req0_ready && !bus.req1_ready &&
            {bus.out_id, bus.out_hundreds, bus.out_tens, bus.out_ones} == 13'h0123))
        hold_ok = 1'b0;
    end
    check("bp_hold", 32'(hold_ok), 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 32'({bus.busy, bus.out_valid, bus.req1_ready}), 3'b001);
    sb.push_back({1'b1, 12'h005});
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    wait_out(0);
    @(posedge clk); #1;
    check("idle_after_bp", 32'({bus.busy, bus.out_valid}), 0);

    // Reset mid-conversion.
    grant(1'b0, 8'd128, 12'h128);
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    bus.req1_bin = 8'd9; bus.req1_valid = 1'b1;
    #1;
    check("rst_mid", 32'({bus.out_valid, bus.busy, bus.out_id, bus.out_hundreds,
                          bus.out_tens, bus.out_ones, bus.req0_ready, bus.req1_ready}), 0);
    repeat (2) @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    send(1'b0, 8'd42, 12'h042);

    // Full sweep against an integer model.
    for (int v = 0; v < 256; v++)
      send(v[0], 8'(v), {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});

    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 SHALL have parameter: W, 8, binary input width (only 8 is supported).
REQ-002 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has a value to convert.
REQ-005 SHALL have port: req0_bin  input  8  requester 0 binary value.
REQ-006 SHALL have port: req0_ready  output  1  requester 0 value accepted this cycle if valid.
REQ-007 SHALL have port: req1_valid  input  1  requester 1 has a value to convert.
REQ-008 SHALL have port: req1_bin  input  8  requester 1 binary value.
REQ-009 SHALL have port: req1_ready  output  1  requester 1 value accepted this cycle if valid.
REQ-010 SHALL have port: out_valid  output  1  result registers hold a finished conversion.
REQ-011 SHALL have port: out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port: out_id  output  1  index of the requester that owns the result.
REQ-013 SHALL have port: out_hundreds  output  4  BCD hundreds digit.
REQ-014 SHALL have port: out_tens  output  4  BCD tens digit.
REQ-015 SHALL have port: out_ones  output  4  BCD ones digit.
REQ-016 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement an FSM with states IDLE, CONVERT, DONE.
REQ-018 SHALL drive reqN_ready only in IDLE, and only for the granted requester; at most one ready is high per cycle.
REQ-019 SHALL grant in IDLE: only one valid -> that one; both valid -> the requester not granted last (round-robin); neither -> no ready.
REQ-020 SHALL derive reqN_ready combinationally from state, valids and last-grant pointer; it must not depend on reqN_bin.
REQ-021 SHALL, on a transfer edge (valid && ready), capture the bin value and the granter index, clear the hundreds/tens/ones shift registers and a 3-bit shift counter, update the last-grant pointer, and enter CONVERT.
REQ-022 SHALL, on each CONVERT edge, first add 3 to every digit (hundreds, tens, ones) that is >= 5, then shift {hundreds,tens,ones,bin} left by one as a 20-bit concatenation, MSB of bin entering ones[0].
REQ-023 SHALL perform exactly 8 shift steps; on the 8th CONVERT edge it SHALL enter DONE with the final digits in the output registers.
REQ-024 SHALL assert out_valid only in DONE, rising on the 8th rising edge after the transfer edge.
REQ-025 SHALL hold out_id and all digits stable while out_valid is high and out_ready is low (backpressure, unbounded).
REQ-026 SHALL return to IDLE on the edge where out_valid && out_ready; out_valid falls on that edge.
REQ-027 SHALL ignore reqN_valid and reqN_bin changes during CONVERT and DONE; pending requesters keep valid high until served.
REQ-028 SHALL produce digits within 0..9 at every digit output; for inputs 0..255, out_hundreds <= 2.
REQ-029 SHALL sustain one conversion every 10 cycles when out_ready is held high and a request is always pending.
REQ-030 SHALL keep output digit values unchanged outside DONE (last result or reset value); only out_valid qualifies them.

Reset
REQ-031 SHALL, while rst_n is low, immediately force: state IDLE, out_valid 0, busy 0, out_id 0, out_hundreds/out_tens/out_ones 0, shift counter 0, last-grant pointer = 1 (so requester 0 wins the first tie).
REQ-032 SHALL, on reset asserted mid-CONVERT or in DONE, abandon the conversion with no out_valid pulse; after release, the first tie grants requester 0.
REQ-033 SHALL deassert both reqN_ready while rst_n is low.

Verification
REQ-034 SHALL verify: req0 sends 255, out_ready=1 -> out_valid 8 edges after accept, out_id=0, digits 2,5,5, busy low after handoff.
REQ-035 SHALL verify corner values 0, 9, 10, 99, 100, 199 -> 0,0,0 / 0,0,9 / 0,1,0 / 0,9,9 / 1,0,0 / 1,9,9; exhaustive sweep 0..255 against an integer model.
REQ-036 SHALL verify: both requesters valid continuously (req0=37, req1=200) -> grants alternate 0,1,0,1 starting with 0 after reset; results 0,3,7 id0 and 2,0,0 id1.
REQ-037 SHALL verify: out_ready low for 20 cycles in DONE -> out_valid and digits held constant, no ready to either requester; out_ready high -> IDLE next edge.
REQ-038 SHALL verify: rst_n pulsed low 4 edges into CONVERT of value 128 -> outputs zero immediately, no out_valid; new request 42 after release -> 0,4,2 at nominal latency.
REQ-039 SHALL verify: req0_bin changed from 50 to 77 during CONVERT -> result 0,5,0.
